// File: rtl/multicycle_ctrl_fsm_pkg.sv
// rtl/multicycle_ctrl_fsm_pkg.sv - shared encodings for the multi-cycle RV32I control FSM
// Opcodes, ALU/mux select encodings, state encoding and the control word layout.
package multicycle_ctrl_fsm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
  localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] ALU_SRC_A_RS1   = 2'b10;
  localparam logic [1:0] ALU_SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RESULT_SRC_ALUOUT  = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEMDATA = 2'b01;
  localparam logic [1:0] RESULT_SRC_ALU     = 2'b10;

  localparam int STATE_ENC_W = 4;

  typedef enum logic [STATE_ENC_W-1:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_LOADWB  = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC_R  = 4'd6,
    ST_EXEC_I  = 4'd7,
    ST_ALUWB   = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JAL     = 4'd10,
    ST_JALR    = 4'd11,
    ST_JALR_WB = 4'd12,
    ST_LUI     = 4'd13,
    ST_AUIPC   = 4'd14,
    ST_HALT    = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_br;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       addr_src;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_word_t;

  // States that talk to memory and therefore may have to wait for mem_ready.
  function automatic logic is_mem_state(state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_ctrl_out_decode.sv
// rtl/multicycle_ctrl_fsm_ctrl_out_decode.sv - state to control-word ROM
// Purely combinational; anything not listed for a state stays 0 / select 00.
module multicycle_ctrl_fsm_ctrl_out_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_a = ALU_SRC_A_PC;
        ctrl.alu_src_b = ALU_SRC_B_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
      end
      // Branch/JAL target is parked in the ALU result register here.
      ST_DECODE: begin
        ctrl.alu_src_a = ALU_SRC_A_OLDPC;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = ALU_SRC_A_RS1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.addr_src = 1'b1;
      end
      ST_LOADWB: begin
        ctrl.result_src = RESULT_SRC_MEMDATA;
        ctrl.reg_write  = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.addr_src  = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = ALU_SRC_A_RS1;
        ctrl.alu_src_b = ALU_SRC_B_RS2;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = ALU_SRC_A_RS1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ITYPE;
      end
      ST_ALUWB: begin
        ctrl.result_src = RESULT_SRC_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a   = ALU_SRC_A_RS1;
        ctrl.alu_src_b   = ALU_SRC_B_RS2;
        ctrl.alu_op      = ALUOP_SUB;
        ctrl.pc_write_br = 1'b1;
        ctrl.result_src  = RESULT_SRC_ALUOUT;
      end
      // Link value comes straight off the ALU while the PC loads the parked target.
      ST_JAL, ST_JALR_WB: begin
        ctrl.alu_src_a  = ALU_SRC_A_OLDPC;
        ctrl.alu_src_b  = ALU_SRC_B_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RESULT_SRC_ALU;
        ctrl.reg_write  = 1'b1;
        ctrl.pc_write   = 1'b1;
      end
      ST_JALR: begin
        ctrl.alu_src_a = ALU_SRC_A_RS1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_LUI: begin
        ctrl.alu_src_a = ALU_SRC_A_ZERO;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_AUIPC: begin
        ctrl.alu_src_a = ALU_SRC_A_OLDPC;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - main control FSM of the multi-cycle RV32I core
// Define MULTICYCLE_MEM_WAIT_EN to make FETCH/MEMRD/MEMWR wait on mem_ready.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int STATE_W         = 4,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_br,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               addr_src,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         result_src,
  output logic               illegal,
  output logic               halted,
  output logic [STATE_W-1:0] state
);

  state_t     state_q;
  logic       illegal_q;
  logic       stall;
  ctrl_word_t rom_word;
  ctrl_word_t ctrl;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign stall = is_mem_state(state_q) && !mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign stall            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        ST_FETCH:  state_q <= ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_q <= ST_MEMADR;
            OP_RTYPE:          state_q <= ST_EXEC_R;
            OP_ITYPE:          state_q <= ST_EXEC_I;
            OP_BRANCH:         state_q <= ST_BRANCH;
            OP_JAL:            state_q <= ST_JAL;
            OP_JALR:           state_q <= ST_JALR;
            OP_LUI:            state_q <= ST_LUI;
            OP_AUIPC:          state_q <= ST_AUIPC;
            OP_SYSTEM:         state_q <= ST_HALT;
            default: begin
              illegal_q <= 1'b1;
              state_q   <= HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
            end
          endcase
        end
        ST_MEMADR:  state_q <= (opcode == OP_LOAD) ? ST_MEMRD : ST_MEMWR;
        ST_MEMRD:   state_q <= ST_LOADWB;
        ST_LOADWB:  state_q <= ST_FETCH;
        ST_MEMWR:   state_q <= ST_FETCH;
        ST_EXEC_R:  state_q <= ST_ALUWB;
        ST_EXEC_I:  state_q <= ST_ALUWB;
        ST_ALUWB:   state_q <= ST_FETCH;
        ST_BRANCH:  state_q <= ST_FETCH;
        ST_JAL:     state_q <= ST_FETCH;
        ST_JALR:    state_q <= ST_JALR_WB;
        ST_JALR_WB: state_q <= ST_FETCH;
        ST_LUI:     state_q <= ST_ALUWB;
        ST_AUIPC:   state_q <= ST_ALUWB;
        ST_HALT:    state_q <= ST_HALT;
        default:    state_q <= ST_FETCH;
      endcase
    end
  end

  multicycle_ctrl_fsm_ctrl_out_decode u_ctrl_out_decode (
    .state (state_q),
    .ctrl  (rom_word)
  );

  // Reset silences the datapath in the same cycle so an abandoned instruction
  // cannot leak a write; a stalled fetch must not bump PC/IR until accepted.
  always_comb begin
    ctrl = rom_word;
`ifdef MULTICYCLE_MEM_WAIT_EN
    if ((state_q == ST_FETCH) && !mem_ready) begin
      ctrl.ir_write = 1'b0;
      ctrl.pc_write = 1'b0;
    end
`endif
    if (rst) begin
      ctrl = '0;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign pc_write_br = ctrl.pc_write_br;
  assign ir_write    = ctrl.ir_write;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign addr_src    = ctrl.addr_src;
  assign reg_write   = ctrl.reg_write;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_op      = ctrl.alu_op;
  assign result_src  = ctrl.result_src;
  assign illegal     = illegal_q;
  assign halted      = (state_q == ST_HALT) && !rst;
  assign state       = STATE_W'(state_q);

endmodule
